pckys_button_reader: RTL and testbench

- Input-side front end for the game top level: reads the raw player buttons arriving on the dedicated input pins and turns them into clean events for the game core.
- Synchronises and debounces each button, then detects press and release transitions.
- Queues one event per transition into a small FIFO.
- The game core drains the FIFO over a valid/ready handshake.

---
 rtl/pckys_button_reader.sv | 182 ++++++++++++++++++
 tb/tb_pckys_button_reader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pckys_button_reader.sv
// Button front end: per-button sync + debounce lanes, press/release pending mask,
// and a small event FIFO drained by the game core over valid/ready.

module pckys_btn_lane #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic btn_in,
  output logic stable,
  output logic flip
);

  localparam logic [7:0] CNT_MAX = 8'(DEB_CYCLES - 1);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       stable_q, stable_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = btn_in;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    flip     = 1'b0;
    // Synchroniser keeps running while disabled; only the debounce freezes.
    if (ena) begin
      if (sync2_q == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
        cnt_d    = '0;
        flip     = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

module pckys_button_reader #(
  parameter int N_BTN      = 8,
  parameter int DEB_CYCLES = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_state,
  output logic             evt_valid,
  output logic [3:0]       evt_code,
  input  logic             evt_ready,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam int IW = $clog2(N_BTN);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [N_BTN-1:0] stable, flip;

  for (genvar g = 0; g < N_BTN; g++) begin : g_lane
    pckys_btn_lane #(.DEB_CYCLES(DEB_CYCLES)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .ena    (ena),
      .btn_in (btn_in[g]),
      .stable (stable[g]),
      .flip   (flip[g])
    );
  end

  logic [N_BTN-1:0]                  pending_q, pending_d;
  logic [FIFO_DEPTH-1:0][IW:0]       mem_q, mem_d;
  logic [PW-1:0]                     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                     count_q, count_d;
  logic                              evt_valid_q, evt_valid_d;
  logic [3:0]                        evt_code_q, evt_code_d;
  logic                              overflow_q, overflow_d;
  logic [IW-1:0]                     push_idx;
  logic                              push, pop, collide;

  // Lowest-index pending button has priority.
  always_comb begin
    push_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pending_q[i]) push_idx = IW'(i);
    end
  end

  // Fullness is judged at cycle start, so a same-cycle pop does not free a slot.
  assign push = ena && (|pending_q) && (count_q < CW'(FIFO_DEPTH));
  assign pop  = evt_valid_q && evt_ready;

  always_comb begin
    pending_d = pending_q;
    collide   = 1'b0;
    if (push) pending_d[push_idx] = 1'b0;
    // A flip on a bit pushed this cycle re-arms it; otherwise a second
    // flip cancels the first and the pair is lost.
    for (int i = 0; i < N_BTN; i++) begin
      if (flip[i]) begin
        if (pending_d[i]) begin
          pending_d[i] = 1'b0;
          collide      = 1'b1;
        end else begin
          pending_d[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    if (collide)      overflow_d = 1'b1;
    else if (clr_ovf) overflow_d = 1'b0;
    else              overflow_d = overflow_q;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {stable[push_idx], push_idx};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d     = count_q + CW'(push) - CW'(pop);
    evt_valid_d = (count_d != '0);
    evt_code_d  = evt_valid_d ? 4'(mem_d[rd_ptr_d]) : 4'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= '0;
      mem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= 4'h0;
      overflow_q  <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      overflow_q  <= overflow_d;
    end
  end

  assign btn_state = stable;
  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pckys_button_reader.sv
// Bench for pckys_button_reader: directed scenarios plus random traffic, all
// checked against a transaction-level model (run lengths, pending set, event queue).

module tb_pckys_button_reader;

  localparam int DEB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] btn_in = 8'h00;
  logic [7:0] btn_state;
  logic       evt_valid;
  logic [3:0] evt_code;
  logic       evt_ready = 1'b1;
  logic       overflow;
  logic       clr_ovf = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  pckys_button_reader #(.N_BTN(8), .DEB_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .btn_in    (btn_in),
    .btn_state (btn_state),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ready (evt_ready),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  wire [13:0] act = {btn_state, evt_valid, evt_code, overflow};

  // Reference model state
  logic [7:0] m_s1, m_s2, m_stab, m_pend;
  int         m_run [8];
  logic [3:0] m_q [$];
  logic       m_ovf;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stab = '0; m_pend = '0; m_ovf = 1'b0;
    for (int i = 0; i < 8; i++) m_run[i] = 0;
    m_q.delete();
  endtask

  // One clock of the spec rules: pop/push decided on start-of-cycle state,
  // a level is accepted after DEB consecutive enabled cycles of disagreement.
  task automatic model_step();
    int         sz;
    bit         do_pop, do_push, collide;
    logic [7:0] p, new_stab;
    logic [2:0] idx;
    logic [3:0] ent;
    sz = m_q.size();
    do_pop = (sz != 0) && evt_ready;
    p = m_pend; do_push = 0; idx = '0; ent = '0; collide = 0;
    if (ena && sz < DEPTH && m_pend != 0) begin
      for (int i = 7; i >= 0; i--) if (m_pend[i]) idx = i[2:0];
      ent = {m_stab[idx], idx};
      p[idx] = 1'b0;
      do_push = 1;
    end
    new_stab = m_stab;
    if (ena) begin
      for (int i = 0; i < 8; i++) begin
        if (m_s2[i] != m_stab[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_run[i] = 0;
            new_stab[i] = m_s2[i];
            if (p[i]) begin p[i] = 1'b0; collide = 1; end
            else p[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    if (do_pop) void'(m_q.pop_front());
    if (do_push) m_q.push_back(ent);
    if (collide) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    m_stab = new_stab; m_pend = p;
    m_s2 = m_s1; m_s1 = btn_in;
  endtask

  function automatic logic [13:0] exp_vec();
    logic v;
    v = (m_q.size() != 0);
    return {m_stab, v, v ? m_q[0] : 4'h0, m_ovf};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b1; btn_in = 8'h00; evt_ready = 1'b1; ena = 1'b1;
    tick(); tick();
    n_cmp++;
    if (act !== 14'h0) begin n_bad++; $display("FAIL reset_hold: got %h want 0000", act); end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_cmp++;
      if (act !== 14'h0) begin n_bad++; $display("FAIL reset_idle cyc %0d: got %h want 0000", k, act); end
    end
  endtask

  task automatic test_press_release();
    btn_in = 8'h04; evt_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      n_cmp++;
      if (act !== exp_vec()) begin n_bad++; $display("FAIL press cyc %0d: got %h want %h", k, act, exp_vec()); end
      if (k == 5) begin
        n_cmp++;
        if (btn_state !== 8'h00) begin n_bad++; $display("FAIL press_early: got %h want 00", btn_state); end
      end
      if (k == 6) begin
        n_cmp++;
        if (btn_state !== 8'h04 || evt_valid !== 1'b0) begin
          n_bad++; $display("FAIL press_edge6: got state %h valid %b want 04 0", btn_state, evt_valid);
        end
      end
      if (k == 7) begin
        n_cmp++;
        if (evt_valid !== 1'b1 || evt_code !== 4'hA) begin
          n_bad++; $display("FAIL press_evt: got valid %b code %h want 1 a", evt_valid, evt_code);
        end
      end
      if (k == 8) begin
        n_cmp++;
        if (evt_valid !== 1'b0) begin n_bad++; $display("FAIL press_pop: got valid %b want 0", evt_valid); end
      end
    end
    btn_in = 8'h00;
    for (int k = 1; k <= 9; k++) begin
      tick();
      n_cmp++;
      if (act !== exp_vec()) begin n_bad++; $display("FAIL release cyc %0d: got %h want %h", k, act, exp_vec()); end
      if (k == 7) begin
        n_cmp++;
        if (evt_valid !== 1'b1 || evt_code !== 4'h2) begin
          n_bad++; $display("FAIL release_evt: got valid %b code %h want 1 2", evt_valid, evt_code);
        end
      end
    end
  endtask

  task automatic test_glitch();
    btn_in = 8'h02;
    for (int k = 0; k < 3; k++) tick();
    btn_in = 8'h00;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_cmp++;
      if (act !== exp_vec() || btn_state !== 8'h00 || evt_valid !== 1'b0) begin
        n_bad++; $display("FAIL glitch cyc %0d: got %h want %h", k, act, exp_vec());
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] seen [$];
    btn_in = 8'h81; evt_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (evt_valid) seen.push_back(evt_code);
      n_cmp++;
      if (act !== exp_vec()) begin n_bad++; $display("FAIL simul cyc %0d: got %h want %h", k, act, exp_vec()); end
    end
    n_cmp++;
    if (seen.size() != 2 || seen[0] !== 4'h8 || seen[1] !== 4'hF) begin
      n_bad++; $display("FAIL simul_order: got %0d events first %h want 2 events 8,f", seen.size(), seen.size() ? seen[0] : 4'h0);
    end
    btn_in = 8'h00;
    for (int k = 0; k < 10; k++) tick();
  endtask

  task automatic test_fill_overflow();
    logic [7:0] seq [6];
    logic [3:0] seen [$];
    seq = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h04, 8'h00};
    evt_ready = 1'b0;
    for (int s = 0; s < 6; s++) begin
      btn_in = seq[s];
      for (int k = 0; k < 7; k++) begin
        tick();
        n_cmp++;
        if (act !== exp_vec()) begin n_bad++; $display("FAIL fill s%0d cyc %0d: got %h want %h", s, k, act, exp_vec()); end
      end
    end
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_code !== 4'h8 || overflow !== 1'b1) begin
      n_bad++; $display("FAIL fill_state: got valid %b code %h ovf %b want 1 8 1", evt_valid, evt_code, overflow);
    end
    evt_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (evt_valid) seen.push_back(evt_code);
      tick();
      n_cmp++;
      if (act !== exp_vec()) begin n_bad++; $display("FAIL drain cyc %0d: got %h want %h", k, act, exp_vec()); end
    end
    n_cmp++;
    if (seen.size() != 4 || seen[0] !== 4'h8 || seen[1] !== 4'h0 || seen[2] !== 4'h9 || seen[3] !== 4'h1) begin
      n_bad++; $display("FAIL drain_order: got %0d events want 4 (8,0,9,1)", seen.size());
    end
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0 || act !== exp_vec()) begin
      n_bad++; $display("FAIL clr_ovf: got ovf %b want 0", overflow);
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int k = 0; k < 1500; k++) begin
      if (hold == 0) begin
        btn_in = btn_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
        hold = $urandom_range(1, 10);
      end
      hold--;
      ena = ($urandom_range(0, 15) != 0);
      evt_ready = ($urandom_range(0, 9) < 6);
      clr_ovf = ($urandom_range(0, 19) == 0);
      tick();
      n_cmp++;
      if (act !== exp_vec()) begin n_bad++; $display("FAIL random cyc %0d: got %h want %h", k, act, exp_vec()); end
    end
    ena = 1'b1; clr_ovf = 1'b0; evt_ready = 1'b1; btn_in = 8'h00;
    for (int k = 0; k < 20; k++) tick();
    n_cmp++;
    if (act !== exp_vec()) begin n_bad++; $display("FAIL random_settle: got %h want %h", act, exp_vec()); end
  endtask

  task automatic test_async_reset();
    evt_ready = 1'b0; clr_ovf = 1'b0; ena = 1'b1;
    btn_in = 8'h38;
    for (int k = 0; k < 9; k++) tick();
    n_cmp++;
    if (act !== exp_vec() || m_q.size() != 3) begin
      n_bad++; $display("FAIL pre_reset: got %h want %h (queue %0d)", act, exp_vec(), m_q.size());
    end
    btn_in = 8'h78;
    for (int k = 0; k < 3; k++) tick();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (act !== 14'h0) begin n_bad++; $display("FAIL async_reset: got %h want 0000", act); end
    model_reset();
    tick();
    rst = 1'b0; evt_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      n_cmp++;
      if (act !== exp_vec()) begin n_bad++; $display("FAIL post_reset cyc %0d: got %h want %h", k, act, exp_vec()); end
      if (k == 5) begin
        n_cmp++;
        if (btn_state !== 8'h00) begin n_bad++; $display("FAIL redetect_early: got %h want 00", btn_state); end
      end
      if (k == 6) begin
        n_cmp++;
        if (btn_state !== 8'h78) begin n_bad++; $display("FAIL redetect: got %h want 78", btn_state); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_glitch();
    test_simultaneous();
    test_fill_overflow();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
